// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: default parameter values and FSM state encoding shared by the cache controller files
package dm_cache_pkg;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int INDEX_W_DEF = 10;
  localparam int OFFSET_W_DEF = 2;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;
endpackage

// File: rtl/dm_cache_if.sv
// dm_cache_if: cpu read/flush port and memory beat port; master drives requests and memory data, slave is the cache
interface dm_cache_if
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic cpu_rd, cpu_flush, cpu_ready, mem_req, mem_ready;
  logic [ADDR_W-1:0] cpu_addr, mem_addr;
  logic [DATA_W-1:0] cpu_data, mem_data;
  modport master(output cpu_rd, cpu_flush, cpu_addr, mem_data, mem_ready,
                 input cpu_data, cpu_ready, mem_req, mem_addr);
  modport slave(input cpu_rd, cpu_flush, cpu_addr, mem_data, mem_ready,
                output cpu_data, cpu_ready, mem_req, mem_addr);
endinterface

// File: rtl/dm_cache_store.sv
// dm_cache_store: tag/valid/data arrays; async read port, word write port, tag+valid write port, flush-all (only valid bits reset)
module dm_cache_store
  import dm_cache_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int TAG_W = ADDR_W_DEF - INDEX_W_DEF - OFFSET_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_word,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                tv_en,
  input  logic [INDEX_W-1:0]  tv_index,
  input  logic [TAG_W-1:0]    tv_tag,
  input  logic                tv_valid
);
  localparam int LINES = 1 << INDEX_W;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [DATA_W-1:0] words [LINES << OFFSET_W];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (flush) valid <= '0;
    else if (tv_en) valid[tv_index] <= tv_valid;
  always_ff @(posedge clk) begin
    if (tv_en) tags[tv_index] <= tv_tag;
    if (wr_en) words[{wr_index, wr_offset}] <= wr_data;
  end
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_word = words[{rd_index, rd_offset}];
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped read cache controller; bus (slave) carries cpu/mem handshakes, hit_count/miss_count saturate
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dm_cache_if.slave        bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [OFFSET_W-1:0] beat;
  logic rd_valid, hit, beat_done, last_beat, flush, wr_en, tv_en, tv_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [DATA_W-1:0] rd_word;
  wire [TAG_W-1:0] tag_q = addr_q[ADDR_W-1 -: TAG_W];
  wire [INDEX_W-1:0] index_q = addr_q[OFFSET_W +: INDEX_W];
  wire [OFFSET_W-1:0] off_q = addr_q[OFFSET_W-1:0];
  assign hit = rd_valid && rd_tag == tag_q;
  assign beat_done = state == REFILL && bus.mem_ready;
  assign last_beat = beat_done && &beat;
  dm_cache_store #(.DATA_W(DATA_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)) u_store (
    .clk(clk), .rst(rst), .flush(flush),
    .rd_index(index_q), .rd_offset(off_q), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_word(rd_word),
    .wr_en(wr_en), .wr_index(index_q), .wr_offset(beat), .wr_data(bus.mem_data),
    .tv_en(tv_en), .tv_index(index_q), .tv_tag(tag_q), .tv_valid(tv_valid)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: state_nx = bus.cpu_rd && !bus.cpu_flush ? LOOKUP : IDLE;
      LOOKUP: state_nx = hit ? RESPOND : REFILL;
      REFILL: state_nx = last_beat ? RESPOND : REFILL;
      default: state_nx = IDLE;
    endcase
  end
  // a miss drops the line's valid bit up front so a half-refilled line never hits
  always_comb begin
    bus.mem_req = state == REFILL;
    bus.mem_addr = state == REFILL ? {tag_q, index_q, beat} : '0;
    flush = state == IDLE && bus.cpu_flush;
    wr_en = beat_done;
    tv_en = (state == LOOKUP && !hit) || last_beat;
    tv_valid = last_beat;
  end
  // cpu_ready/cpu_data are registered, so the response appears the clock after RESPOND
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      beat <= '0;
      hit_count <= '0;
      miss_count <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_data <= '0;
    end else begin
      bus.cpu_ready <= state == RESPOND;
      if (state == IDLE && bus.cpu_rd && !bus.cpu_flush) addr_q <= bus.cpu_addr;
      if (state == LOOKUP && hit) begin
        bus.cpu_data <= rd_word;
        hit_count <= hit_count + CNT_W'(!(&hit_count));
      end
      if (state == LOOKUP && !hit) begin
        miss_count <= miss_count + CNT_W'(!(&miss_count));
        beat <= '0;
      end
      if (beat_done) begin
        beat <= beat + 1'b1;
        if (beat == off_q) bus.cpu_data <= bus.mem_data;
      end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: scoreboard bench for dm_cache_ctrl with a mem_data = mem_addr memory model
module tb_dm_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] hit_count, miss_count;
  int total = 0, bad = 0, exp_hit = 0, exp_miss = 0;
  logic [31:0] exp_q[$], beat_q[$];
  always #5 clk = ~clk;
  dm_cache_if #(.ADDR_W(15), .DATA_W(32)) bus ();
  dm_cache_ctrl #(.ADDR_W(15), .DATA_W(32), .INDEX_W(10), .OFFSET_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );
  assign bus.mem_data = {17'b0, bus.mem_addr};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v > 15 ? 15 : v;
  endfunction
  always begin
    @(negedge clk);
    #1;
    if (bus.cpu_ready) begin
      if (exp_q.size() == 0) chk("ready_unexpected", {31'b0, bus.cpu_ready}, 0);
      else chk("rdata", bus.cpu_data, exp_q.pop_front());
    end
    if (bus.mem_req && bus.mem_ready) begin
      if (beat_q.size() == 0) chk("beat_unexpected", {31'b0, bus.mem_req}, 0);
      else chk("beat_addr", {17'b0, bus.mem_addr}, beat_q.pop_front());
    end
  end
  task automatic rd(input logic [14:0] a, input bit miss, input int lat);
    int n;
    exp_q.push_back({17'b0, a});
    if (miss) for (int i = 0; i < 4; i++) beat_q.push_back({17'b0, a[14:2], 2'(i)});
    bus.cpu_addr = a;
    bus.cpu_rd = 1'b1;
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    n = 1;
    while (!bus.cpu_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    if (miss) exp_miss = sat(exp_miss + 1);
    else exp_hit = sat(exp_hit + 1);
    chk("hit_count", {28'b0, hit_count}, exp_hit);
    chk("miss_count", {28'b0, miss_count}, exp_miss);
  endtask
  task automatic flush(input bit with_rd);
    bus.cpu_flush = 1'b1;
    bus.cpu_rd = with_rd;
    bus.cpu_addr = 15'h1005;
    @(negedge clk);
    bus.cpu_flush = 1'b0;
    bus.cpu_rd = 1'b0;
  endtask
  initial begin
    bit ok;
    int n;
    bus.cpu_rd = 1'b0;
    bus.cpu_flush = 1'b0;
    bus.cpu_addr = '0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", {31'b0, bus.cpu_ready}, 0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("rst_mem_addr", {17'b0, bus.mem_addr}, 0);
    chk("rst_cpu_data", bus.cpu_data, 0);
    chk("rst_hit", {28'b0, hit_count}, 0);
    chk("rst_miss", {28'b0, miss_count}, 0);
    rst = 1'b0;
    @(negedge clk);
    rd(15'h1005, 1, 7);
    rd(15'h1006, 0, 3);
    rd(15'h1007, 0, 3);
    rd(15'h1004, 0, 3);
    rd(15'h2005, 1, 7);
    rd(15'h1005, 1, 7);
    rd(15'h1004, 0, 3);
    flush(1);
    repeat (4) @(negedge clk);
    chk("flush_hit", {28'b0, hit_count}, exp_hit);
    chk("flush_miss", {28'b0, miss_count}, exp_miss);
    rd(15'h1005, 1, 7);
    flush(0);
    fork
      rd(15'h1005, 1, 12);
      begin
        n = 0;
        while (!(bus.mem_req && bus.mem_addr == 15'h1005) && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("stall_seen", {31'b0, n < 50}, 1);
        bus.mem_ready = 1'b0;
        ok = 1'b1;
        repeat (5) begin
          @(negedge clk);
          ok &= bus.mem_req && bus.mem_addr == 15'h1005;
        end
        bus.mem_ready = 1'b1;
        chk("stall_hold", {31'b0, ok}, 1);
      end
    join
    for (int i = 0; i < 13; i++) rd(15'(15'h1004 + i % 4), 0, 3);
    chk("hit_sat", {28'b0, hit_count}, 15);
    for (int i = 0; i < 12; i++) rd(i % 2 ? 15'h1005 : 15'h2005, 1, 7);
    chk("miss_sat", {28'b0, miss_count}, 15);
    flush(0);
    for (int i = 0; i < 4; i++) beat_q.push_back({17'b0, 13'h0401, 2'(i)});
    bus.cpu_addr = 15'h1005;
    bus.cpu_rd = 1'b1;
    @(negedge clk);
    bus.cpu_rd = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 15'h1006) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat2_seen", {31'b0, n < 50}, 1);
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", {31'b0, bus.mem_req}, 0);
    chk("midrst_mem_addr", {17'b0, bus.mem_addr}, 0);
    chk("midrst_hit", {28'b0, hit_count}, 0);
    chk("midrst_miss", {28'b0, miss_count}, 0);
    beat_q.delete();
    exp_q.delete();
    exp_hit = 0;
    exp_miss = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(15'h1005, 1, 7);
    repeat (3) @(negedge clk);
    chk("queues_drained", exp_q.size() + beat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
